retire_stage: RTL and testbench
===============================

# retire_stage

In-order commit stage sitting at the head of the ROB: consumes the ROB's `head_entries`/`head_valids`, retires the oldest contiguous run of completed entries (up to `N` per cycle), frees `prev_phys_rd` tags to the free list and maintains the architectural map table. It is the source of the ROB's `mispredict`/`mispred_idx` inputs. On a retiring branch mispredict it issues a one-cycle flush with a redirect PC. On a halt or illegal instruction it stops the machine.

## Interface
Parameters, all from `sys_defs.svh`:
- `N`, default 3: retire width.
- `ROB_SZ`, default 32: ROB depth, a power of two.
- `ARCH_REGS`, default 32: architectural registers. Register 0 is hardwired.

Ports:
- `clock  in  1`: single clock.
- `reset  in  1`: synchronous, active-high.
- `head_entries  in  ROB_ENTRY[N-1:0]`: oldest `N` ROB entries. Slot 0 is the oldest.
- `head_valids  in  N`: slot holds a valid, complete entry.
- `head_idx  in  ROB_IDX`: ROB index of slot 0.
- `retire_mask  out  N`: slots committed this cycle. The ROB advances head by `popcount(retire_mask)`.
- `free_valid  out  N`: per slot, a tag is returned to the free list.
- `free_tags  out  PHYS_TAG[N-1:0]`: the `prev_phys_rd` of each committed slot.
- `mispredict  out  1`: flush pulse to the ROB and front end.
- `mispred_idx  out  ROB_IDX`: ROB index of the mispredicted branch.
- `redirect_pc  out  ADDR`: correct next PC.
- `arch_map  out  PHYS_TAG[ARCH_REGS-1:0]`: committed map, used to restore rename on a flush.
- `halted  out  1`: machine stopped.
- `retire_count  out  $clog2(N+1)`: equals `popcount(retire_mask)`.

## Operation
- State machine `RETIRE_STATE`, with states RUN, FLUSH and HALT. Reset puts it in RUN.
- Candidate slots (RUN only): slot k is a candidate iff `head_valids[0..k]` are all 1. This is a prefix; a gap stops retirement.
- Mispredict test for slot k: `branch && (branch_taken != pred_taken || (branch_taken && branch_target != pred_target))`.
- `retire_mask` is the candidate prefix, truncated inclusively at the first slot that mispredicts, has `halt` set, or has `illegal` set.
- Terminating slot j is a mispredict:
  - Next state is FLUSH.
  - Register `mispred_idx = head_idx + j` (mod `ROB_SZ`; natural wrap).
  - Register `redirect_pc = branch_taken ? branch_target : PC + 4`.
- Terminating slot is a halt or illegal: next state is HALT.
- FLUSH:
  - `mispredict` = 1 for exactly one cycle.
  - `retire_mask` = 0; wrong-path heads are ignored.
  - Then return to RUN.
- HALT:
  - `retire_mask` = 0 forever.
  - `halted` = 1.
  - Exit only by reset.
- Map update for each committed slot with `arch_rd != 0`: `arch_map[arch_rd] <= phys_rd`. If several slots in a group write the same `arch_rd`, the youngest slot wins.
- Free list: `free_valid[k] = retire_mask[k] && arch_rd != 0`, and `free_tags[k] = prev_phys_rd`. Slots with `arch_rd == 0` free nothing.

## Timing
- `retire_mask`, `free_valid`, `free_tags` and `retire_count` are combinational from the inputs and the current state.
- The map and state update at the posedge of the cycle in which an entry commits.
- `mispredict`, `mispred_idx` and `redirect_pc` are registered: they are valid the cycle after the branch commits.
- Reset values:
  - state RUN
  - `mispredict` 0
  - `mispred_idx` 0
  - `redirect_pc` 0
  - `halted` 0
  - `arch_map[i] = i` (identity)
  - `retire_mask` 0 during reset
- Reset asserted in FLUSH or HALT: next cycle is RUN, with `mispredict` 0 and the map at identity.
- A mispredict in slot `N-1` behaves the same as in any other slot; nothing older is suppressed.
- A `head_idx` wrap (e.g. 31, j=2 → `mispred_idx` 1) wraps modulo `ROB_SZ`.

## Structure
- Add to `sys_defs.svh`:
  - `RETIRE_STATE` enum.
  - `ARCH_REGS` macro.
- Sub-module `branch_check`: a combinational per-slot mispredict/redirect detector, instantiated `N` times.
- The top level holds the prefix/truncate logic, the FSM, the map registers and the output registers.

## Test plan
Bench configuration: N=3, ROB_SZ=32.
- Map identity after reset:
  - Stimulus: reset 2 cycles.
  - Required: `arch_map[5]==5`, `halted==0`, `mispredict==0`.
- Plain retire:
  - Stimulus: `head_valids=3'b111`, arch_rd 1/2/3, phys 10/11/12, prev 1/2/3.
  - Required: `retire_mask=111`, `free_tags={3,2,1}`, next cycle `arch_map[1..3]={10,11,12}`.
- Prefix gap:
  - Stimulus: `head_valids=3'b101`.
  - Required: `retire_mask=001`, `retire_count=1`.
- Mispredict with wrap:
  - Stimulus: `head_idx=31`; slot 1 branch, taken, target 0x2000, pred not taken.
  - Required: `retire_mask=011`; next cycle `mispredict=1`, `mispred_idx=0`, `redirect_pc=0x2000`, `retire_mask=0`; the cycle after, RUN.
- Same-register collision and reg 0:
  - Stimulus: slots 0 and 2 write r4 with phys 20 and 22; slot 1 has `arch_rd=0`.
  - Required: `arch_map[4]=22`, `free_valid=101`.
- Halt, then reset:
  - Stimulus: halt in slot 0, then hold `head_valids=111` for 5 cycles.
  - Required: `retire_mask=001`, then 0 for 5 cycles with `halted=1`; after reset, `halted=0` and the map is identity.

Source files
------------

// File: rtl/retire_stage_pkg.sv
// Shared types for the in-order retire stage: ROB entry layout, tag/address
// widths and the retire state machine encoding.
package retire_stage_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int ARCH_W        = $clog2(NUM_ARCH_REGS);
    localparam int PHYS_W        = 6;
    localparam int ADDR_W        = 32;

    typedef logic [PHYS_W-1:0] phys_tag_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ARCH_W-1:0] arch_reg_t;

    typedef enum logic [1:0] {
        RS_RUN,
        RS_FLUSH,
        RS_HALT
    } retire_state_t;

    typedef struct packed {
        addr_t     pc;
        logic      branch;
        logic      branch_taken;
        logic      pred_taken;
        addr_t     branch_target;
        addr_t     pred_target;
        logic      halt;
        logic      illegal;
        arch_reg_t arch_rd;
        phys_tag_t phys_rd;
        phys_tag_t prev_phys_rd;
    } rob_entry_t;

endpackage

// File: rtl/retire_stage_branch_check.sv
// Per-slot branch resolution: flags a mispredicted branch and produces the
// PC the front end should restart from.
module branch_check
    import retire_stage_pkg::*;
(
    input  addr_t pc,
    input  logic  branch,
    input  logic  branch_taken,
    input  logic  pred_taken,
    input  addr_t branch_target,
    input  addr_t pred_target,
    output logic  mispredict,
    output addr_t redirect_pc
);

    always_comb begin
        mispredict  = branch && ((branch_taken != pred_taken) ||
                                 (branch_taken && (branch_target != pred_target)));
        redirect_pc = branch_taken ? branch_target : pc + addr_t'(4);
    end

endmodule

// File: rtl/retire_stage.sv
// Commit stage at the ROB head: retires the oldest contiguous run of complete
// entries, frees old tags, keeps the architectural map and raises flush/halt.
module retire_stage
    import retire_stage_pkg::*;
#(
    parameter  int N         = 3,
    parameter  int ROB_SZ    = 32,
    parameter  int ARCH_REGS = NUM_ARCH_REGS,
    localparam int IDX_W     = $clog2(ROB_SZ),
    localparam int CNT_W     = $clog2(N + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  rob_entry_t [N-1:0]         head_entries,
    input  logic [N-1:0]               head_valids,
    input  logic [IDX_W-1:0]           head_idx,
    output logic [N-1:0]               retire_mask,
    output logic [N-1:0]               free_valid,
    output phys_tag_t [N-1:0]          free_tags,
    output logic                       mispredict,
    output logic [IDX_W-1:0]           mispred_idx,
    output addr_t                      redirect_pc,
    output phys_tag_t [ARCH_REGS-1:0]  arch_map,
    output logic                       halted,
    output logic [CNT_W-1:0]           retire_count
);

    retire_state_t    state;
    logic [N-1:0]     slot_mispred;
    addr_t            slot_redirect [N];
    logic             take_flush;
    logic             take_halt;
    logic [IDX_W-1:0] term_idx;
    addr_t            term_pc;

    for (genvar k = 0; k < N; k++) begin : g_branch_check
        branch_check u_branch_check (
            .pc            (head_entries[k].pc),
            .branch        (head_entries[k].branch),
            .branch_taken  (head_entries[k].branch_taken),
            .pred_taken    (head_entries[k].pred_taken),
            .branch_target (head_entries[k].branch_target),
            .pred_target   (head_entries[k].pred_target),
            .mispredict    (slot_mispred[k]),
            .redirect_pc   (slot_redirect[k])
        );
    end

    // Walk slots oldest-first; `alive` drops at the first gap or terminating slot.
    always_comb begin
        logic alive;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        retire_mask  = '0;
        retire_count = '0;
        take_flush   = 1'b0;
        take_halt    = 1'b0;
        term_idx     = head_idx;
        term_pc      = '0;
        // NOTE: blocking assignments here are deliberate; `alive` must update within one pass of the loop.
        alive        = (state == RS_RUN) && !reset;
        for (int k = 0; k < N; k++) begin
            alive = alive && head_valids[k];
            if (alive) begin
                retire_mask[k] = 1'b1;
                retire_count   = retire_count + CNT_W'(1);
                if (head_entries[k].halt || head_entries[k].illegal) begin
                    take_halt = 1'b1;
                    alive     = 1'b0;
                end else if (slot_mispred[k]) begin
                    take_flush = 1'b1;
                    term_idx   = head_idx + IDX_W'(k);
                    term_pc    = slot_redirect[k];
                    alive      = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            free_valid[k] = retire_mask[k] && (head_entries[k].arch_rd != '0);
            free_tags[k]  = head_entries[k].prev_phys_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RS_RUN;
            mispredict  <= 1'b0;
            mispred_idx <= '0;
            redirect_pc <= '0;
            halted      <= 1'b0;
            // NOTE: the map is a register file that must come out of reset as identity, so it is reset explicitly.
            for (int i = 0; i < ARCH_REGS; i++) begin
                arch_map[i] <= phys_tag_t'(i);
            end
        end else begin
            mispredict <= take_flush;
            if (take_flush) begin
                mispred_idx <= term_idx;
                redirect_pc <= term_pc;
            end
            case (state)
                RS_RUN: begin
                    if (take_halt) begin
                        state  <= RS_HALT;
                        halted <= 1'b1;
                    end else if (take_flush) begin
                        state <= RS_FLUSH;
                    end
                end
                RS_FLUSH: state <= RS_RUN;
                default:  state <= RS_HALT;
            endcase
            // Later slots are younger; their write lands last and wins on collision.
            for (int k = 0; k < N; k++) begin
                if (retire_mask[k] && (head_entries[k].arch_rd != '0)) begin
                    arch_map[head_entries[k].arch_rd] <= head_entries[k].phys_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_retire_stage.sv
// Randomised plus directed bench for retire_stage with a queue-based scoreboard
// fed by a behavioural commit model.
module tb_retire_stage;
    import retire_stage_pkg::*;

    localparam int N      = 3;
    localparam int ROB_SZ = 32;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 2;

    logic                      clock = 1'b0;
    logic                      reset;
    rob_entry_t [N-1:0]        head_entries;
    logic [N-1:0]              head_valids;
    logic [IDX_W-1:0]          head_idx;
    logic [N-1:0]              retire_mask;
    logic [N-1:0]              free_valid;
    phys_tag_t [N-1:0]         free_tags;
    logic                      mispredict;
    logic [IDX_W-1:0]          mispred_idx;
    addr_t                     redirect_pc;
    phys_tag_t [31:0]          arch_map;
    logic                      halted;
    logic [CNT_W-1:0]          retire_count;

    always #5 clock = ~clock;

    retire_stage #(.N(N), .ROB_SZ(ROB_SZ), .ARCH_REGS(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .head_entries (head_entries),
        .head_valids  (head_valids),
        .head_idx     (head_idx),
        .retire_mask  (retire_mask),
        .free_valid   (free_valid),
        .free_tags    (free_tags),
        .mispredict   (mispredict),
        .mispred_idx  (mispred_idx),
        .redirect_pc  (redirect_pc),
        .arch_map     (arch_map),
        .halted       (halted),
        .retire_count (retire_count)
    );

    typedef struct {
        bit                chk_reg;
        logic [N-1:0]      mask;
        int                count;
        logic [N-1:0]      fv;
        phys_tag_t [N-1:0] tags;
        bit                mp;
        int                mp_idx;
        addr_t             mp_pc;
        bit                hl;
        phys_tag_t [31:0]  map;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model of architectural state as seen on the DUT outputs
    bit               m_known = 0;
    bit               m_flush = 0;
    bit               m_halt  = 0;
    int               m_idx   = 0;
    addr_t            m_pc    = '0;
    phys_tag_t [31:0] m_map;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_mispred(input rob_entry_t e);
        if (!e.branch) return 0;
        if (e.branch_taken != e.pred_taken) return 1;
        return e.branch_taken && (e.branch_target != e.pred_target);
    endfunction

    function automatic rob_entry_t mk(input int arch, input int phys, input int prev);
        rob_entry_t e;
        e              = '0;
        e.pc           = 32'h1000;
        e.arch_rd      = arch_reg_t'(arch);
        e.phys_rd      = phys_tag_t'(phys);
        e.prev_phys_rd = phys_tag_t'(prev);
        return e;
    endfunction

    function automatic rob_entry_t rand_entry();
        rob_entry_t e;
        e               = '0;
        e.pc            = addr_t'({$urandom_range(0, 16'hffff), 2'b00});
        e.arch_rd       = arch_reg_t'($urandom_range(0, 31));
        e.phys_rd       = phys_tag_t'($urandom_range(0, 63));
        e.prev_phys_rd  = phys_tag_t'($urandom_range(0, 63));
        e.halt          = ($urandom_range(0, 59) == 0);
        e.illegal       = ($urandom_range(0, 59) == 0);
        if (!e.halt && !e.illegal && $urandom_range(0, 2) == 0) begin
            e.branch        = 1'b1;
            e.branch_taken  = $urandom_range(0, 1) != 0;
            e.pred_taken    = ($urandom_range(0, 2) == 0) ? !e.branch_taken : e.branch_taken;
            e.branch_target = addr_t'({$urandom_range(0, 16'hffff), 2'b00});
            e.pred_target   = ($urandom_range(0, 2) == 0) ? e.branch_target + 32'h10 : e.branch_target;
        end
        return e;
    endfunction

    // Drive one cycle of inputs, push what the DUT must show, advance the model.
    task automatic step(input rob_entry_t [N-1:0] e, input logic [N-1:0] v,
                        input logic [IDX_W-1:0] hidx, input bit rst);
        exp_t x;
        int   n;
        bit   term_mp;
        bit   term_halt;
        head_entries = e;
        head_valids  = v;
        head_idx     = hidx;
        reset        = rst;
        x.chk_reg = m_known;
        x.mp      = m_flush;
        x.mp_idx  = m_idx;
        x.mp_pc   = m_pc;
        x.hl      = m_halt;
        x.map     = m_map;
        n = 0; term_mp = 0; term_halt = 0;
        if (!rst && m_known && !m_flush && !m_halt) begin
            while (n < N && v[n]) begin
                n++;
                if (e[n-1].halt || e[n-1].illegal) begin term_halt = 1; break; end
                if (is_mispred(e[n-1])) begin term_mp = 1; break; end
            end
        end
        x.mask  = N'((1 << n) - 1);
        x.count = n;
        x.fv    = '0;
        x.tags  = '0;
        for (int k = 0; k < n; k++) begin
            x.fv[k]   = (e[k].arch_rd != 0);
            x.tags[k] = e[k].prev_phys_rd;
        end
        if (rst) begin
            m_known = 1; m_flush = 0; m_halt = 0; m_idx = 0; m_pc = '0;
            for (int r = 0; r < 32; r++) m_map[r] = phys_tag_t'(r);
        end else begin
            for (int k = 0; k < n; k++)
                if (e[k].arch_rd != 0) m_map[e[k].arch_rd] = e[k].phys_rd;
            m_flush = 0;
            if (term_mp) begin
                m_flush = 1;
                m_idx   = (int'(hidx) + n - 1) % ROB_SZ;
                m_pc    = e[n-1].branch_taken ? e[n-1].branch_target : e[n-1].pc + 32'd4;
            end
            if (term_halt) m_halt = 1;
        end
        sb.push_back(x);
        @(posedge clock);
        #2;
    endtask

    // Monitor: compares DUT outputs mid-cycle against the oldest expectation
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("retire_mask", retire_mask, x.mask);
                check("retire_count", retire_count, x.count);
                check("free_valid", free_valid, x.fv);
                for (int k = 0; k < x.count; k++)
                    check($sformatf("free_tags[%0d]", k), free_tags[k], x.tags[k]);
                if (x.chk_reg) begin
                    check("mispredict", mispredict, x.mp);
                    check("halted", halted, x.hl);
                    if (x.mp) begin
                        check("mispred_idx", mispred_idx, x.mp_idx);
                        check("redirect_pc", redirect_pc, x.mp_pc);
                    end
                    for (int r = 0; r < 32; r++)
                        check($sformatf("arch_map[%0d]", r), arch_map[r], x.map[r]);
                end
            end
        end
    end

    initial begin
        rob_entry_t [N-1:0] e;
        logic [N-1:0]       v;
        reset        = 1'b1;
        head_entries = '0;
        head_valids  = '0;
        head_idx     = '0;
        @(posedge clock);
        #2;

        e = '0;
        step(e, 3'b000, 5'd0, 1);
        step(e, 3'b000, 5'd0, 1);
        step(e, 3'b000, 5'd0, 0);

        // Plain three-wide retire
        e[0] = mk(1, 10, 1); e[1] = mk(2, 11, 2); e[2] = mk(3, 12, 3);
        step(e, 3'b111, 5'd4, 0);
        step(e, 3'b000, 5'd7, 0);

        // Gap in valids stops retirement after slot 0
        e[0] = mk(6, 30, 6); e[1] = mk(7, 31, 7); e[2] = mk(8, 32, 8);
        step(e, 3'b101, 5'd7, 0);

        // Mispredict in slot 1 with head index wrap
        e[0] = mk(9, 40, 9); e[1] = mk(0, 0, 0); e[2] = mk(10, 41, 10);
        e[1].branch        = 1'b1;
        e[1].branch_taken  = 1'b1;
        e[1].branch_target = 32'h2000;
        e[1].pred_taken    = 1'b0;
        step(e, 3'b111, 5'd31, 0);
        step(e, 3'b111, 5'd1, 0);
        e[0] = mk(11, 42, 11);
        step(e, 3'b001, 5'd1, 0);

        // Same-register collision; r0 frees nothing
        e[0] = mk(4, 20, 4); e[1] = mk(0, 21, 5); e[2] = mk(4, 22, 20);
        step(e, 3'b111, 5'd2, 0);
        step(e, 3'b000, 5'd5, 0);

        // Mispredict in the last slot, not-taken direction
        e[0] = mk(12, 43, 12); e[1] = mk(13, 44, 13); e[2] = mk(14, 45, 14);
        e[2].pc         = 32'h3000;
        e[2].branch     = 1'b1;
        e[2].pred_taken = 1'b1;
        step(e, 3'b111, 5'd10, 0);
        step(e, 3'b111, 5'd13, 0);
        step(e, 3'b000, 5'd13, 0);

        // Halt in slot 0, then stuck until reset
        e[0] = mk(15, 46, 15); e[1] = mk(16, 47, 16); e[2] = mk(17, 48, 17);
        e[0].halt = 1'b1;
        step(e, 3'b111, 5'd13, 0);
        e[0].halt = 1'b0;
        for (int i = 0; i < 5; i++) step(e, 3'b111, 5'd14, 0);
        step(e, 3'b111, 5'd14, 1);
        step(e, 3'b000, 5'd0, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) e[k] = rand_entry();
            v = N'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) v = 3'b111;
            step(e, v, IDX_W'($urandom_range(0, 31)),
                 ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 3) == 0));
        end

        step(e, 3'b000, 5'd0, 0);
        repeat (3) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
